// File: rtl/inv_mix_columns_seq_if.sv
// Valid/ready bundle for inv_mix_columns_seq; the fwd select line exists only
// when INV_MIX_COLUMNS_FWD_EN is defined.
interface inv_mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
`ifdef INV_MIX_COLUMNS_FWD_EN
    logic         fwd;

    modport master (
        output in_valid, state_in, out_ready, fwd,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, state_in, out_ready, fwd,
        output in_ready, out_valid, state_out
    );
`else
    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out
    );
`endif
endinterface

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine, COLS_PER_CYCLE columns per clock.
// Defining INV_MIX_COLUMNS_FWD_EN adds a per-state fwd select for forward MixColumns.
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inv_mix_columns_seq_if.slave  bus
);

    if (COLS_PER_CYCLE != 32'sd1 && COLS_PER_CYCLE != 32'sd2 && COLS_PER_CYCLE != 32'sd4) begin : g_bad_cpc
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [2:0] CPC_W = 3'(COLS_PER_CYCLE);
    localparam logic [1:0] STEP  = CPC_W[1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_next_s;
    logic [127:0] work_r;
    logic [127:0] work_next_s;
    logic [1:0]   col_idx_r;
    logic [1:0]   col_idx_next_s;
    logic         fwd_r;
    logic         fwd_next_s;
    logic         fwd_in_s;
    logic         load_s;
    logic         step_s;
    logic         last_group_s;
    logic [3:0]   in_group_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // One column through either coefficient set; every multiple is an xtime chain.
    function automatic logic [31:0] col_xform(input logic [31:0] col, input logic fwd);
        logic [7:0]  a  [4];
        logic [7:0]  m2 [4];
        logic [7:0]  m4 [4];
        logic [7:0]  m8 [4];
        logic [31:0] res;
        res = 32'd0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            m2[i] = xtime(a[i]);
            m4[i] = xtime(m2[i]);
            m8[i] = xtime(m4[i]);
        end
        for (int r = 0; r < 4; r++) begin
            if (fwd) begin
                res[31-8*r -: 8] = m2[r] ^ (m2[(r+1)%4] ^ a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
            end else begin
                res[31-8*r -: 8] = (m8[r] ^ m4[r] ^ m2[r])
                                 ^ (m8[(r+1)%4] ^ m2[(r+1)%4] ^ a[(r+1)%4])
                                 ^ (m8[(r+2)%4] ^ m4[(r+2)%4] ^ a[(r+2)%4])
                                 ^ (m8[(r+3)%4] ^ a[(r+3)%4]);
            end
        end
        return res;
    endfunction

`ifdef INV_MIX_COLUMNS_FWD_EN
    assign fwd_in_s = bus.fwd;
`else
    assign fwd_in_s = 1'b0;
`endif

    // The group ends when col_idx+CPC wraps to zero.
    assign last_group_s = ((col_idx_r + STEP) == 2'd0);

    // Columns touched this cycle are col_idx .. col_idx+CPC-1.
    always_comb begin
        in_group_s = 4'd0;
        for (int c = 0; c < 4; c++) begin
            in_group_s[c] = ({1'b0, 2'(c) - col_idx_r} < CPC_W);
        end
    end

    // Next-state and load/step decode.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    load_s       = 1'b1;
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                step_s = 1'b1;
                if (last_group_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (bus.out_ready && bus.in_valid) begin
                    load_s       = 1'b1;
                    state_next_s = BUSY;
                end else if (bus.out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Work register update: load a fresh state or transform the current column group in place.
    always_comb begin
        work_next_s    = work_r;
        col_idx_next_s = col_idx_r;
        fwd_next_s     = fwd_r;
        if (load_s) begin
            work_next_s    = bus.state_in;
            col_idx_next_s = 2'd0;
            fwd_next_s     = fwd_in_s;
        end else if (step_s) begin
            for (int c = 0; c < 4; c++) begin
                if (in_group_s[c]) begin
                    work_next_s[127-32*c -: 32] = col_xform(work_r[127-32*c -: 32], fwd_r);
                end else begin
                    work_next_s[127-32*c -: 32] = work_r[127-32*c -: 32];
                end
            end
            col_idx_next_s = col_idx_r + STEP;
        end else begin
            work_next_s = work_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath registers; reset clears any in-flight state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work_r    <= 128'd0;
            col_idx_r <= 2'd0;
            fwd_r     <= 1'b0;
        end else begin
            work_r    <= work_next_s;
            col_idx_r <= col_idx_next_s;
            fwd_r     <= fwd_next_s;
        end
    end

    assign bus.in_ready  = rst_n & ((state_r == IDLE) | ((state_r == DONE) & bus.out_ready));
    assign bus.out_valid = (state_r == DONE);
    assign bus.state_out = work_r;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Scoreboard bench for inv_mix_columns_seq; CPC selects COLS_PER_CYCLE.
module tb_inv_mix_columns_seq;
    parameter int CPC = 1;
    localparam int LAT = 4 / CPC;
    localparam logic [127:0] V_IN  = 128'h046681E5E0CB199A48F8D37A2806264C;
    localparam logic [127:0] V_OUT = 128'hD4BF5D30E0B452AEB84111F11E2798E5;

    logic clk = 1'b0;
    logic rst_n;
    int total = 0;
    int bad = 0;
    logic [127:0] exp_q[$];
`ifdef INV_MIX_COLUMNS_FWD_EN
    logic fwd_sel = 1'b0;
`endif

    inv_mix_columns_seq_if bus ();
    inv_mix_columns_seq #(.COLS_PER_CYCLE(CPC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Shift-and-add GF(2^8) multiply used by the reference model.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] mdl(input logic [127:0] s, input bit f);
        logic [7:0] co [4];
        logic [7:0] acc;
        logic [127:0] r;
        r = 128'd0;
        if (f) co = '{8'h02, 8'h03, 8'h01, 8'h01};
        else   co = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(co[(j - row + 4) % 4], s[127-32*c-8*j -: 8]);
                r[127-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic send(input logic [127:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.state_in = d;
`ifdef INV_MIX_COLUMNS_FWD_EN
        bus.fwd = fwd_sel;
`endif
        #1;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL wait_out_timeout out_valid=%b required=1", bus.out_valid);
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.state_out !== 128'd0) begin bad++; $display("FAIL rst_state_out got=%h want=0", bus.state_out); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_vector();
        int n;
        logic [127:0] e;
        exp_q.push_back(V_OUT);
        send(V_IN);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL early_valid got=%b want=0", bus.out_valid); end
        wait_out(n);
        total++; if (n !== LAT) begin bad++; $display("FAIL latency got=%0d want=%0d", n, LAT); end
        e = exp_q.pop_front();
        total++; if (bus.state_out !== e) begin bad++; $display("FAIL vector got=%h want=%h", bus.state_out, e); end
        take();
    endtask

    task automatic test_columns();
        logic [127:0] ins [5];
        logic [127:0] outs [5];
        logic [127:0] e;
        int n;
        ins[0] = {4{32'h8E4DA1BC}}; outs[0] = {4{32'hDB135345}};
        ins[1] = {4{32'h01010101}}; outs[1] = {4{32'h01010101}};
        ins[2] = 128'd0;            outs[2] = 128'd0;
        ins[3] = {$urandom, $urandom, $urandom, $urandom}; outs[3] = mdl(ins[3], 1'b0);
        ins[4] = {$urandom, $urandom, $urandom, $urandom}; outs[4] = mdl(ins[4], 1'b0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(outs[i]);
            send(ins[i]);
            wait_out(n);
            e = exp_q.pop_front();
            total++; if (bus.state_out !== e) begin bad++; $display("FAIL column_%0d got=%h want=%h", i, bus.state_out, e); end
            take();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] r1, r2, e;
        int n;
        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom, $urandom};
        exp_q.push_back(mdl(r1, 1'b0));
        send(r1);
        wait_out(n);
        bus.in_valid = 1'b1;
        bus.state_in = r2;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b want=1", i, bus.out_valid); end
            total++; if (bus.state_out !== exp_q[0]) begin bad++; $display("FAIL bp_stable cyc=%0d got=%h want=%h", i, bus.state_out, exp_q[0]); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, bus.in_ready); end
        end
        exp_q.push_back(mdl(r2, 1'b0));
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b want=1", bus.in_ready); end
        e = exp_q.pop_front();
        total++; if (bus.state_out !== e) begin bad++; $display("FAIL bp_first got=%h want=%h", bus.state_out, e); end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_accept got=%b want=0", bus.out_valid); end
        wait_out(n);
        e = exp_q.pop_front();
        total++; if (bus.state_out !== e) begin bad++; $display("FAIL bp_second got=%h want=%h", bus.state_out, e); end
        take();
    endtask

    task automatic test_reset_midop();
        int skip;
        int n;
        logic [127:0] e;
        skip = (CPC == 4) ? 0 : (2 / CPC);
        exp_q.push_back(V_OUT);
        send(V_IN);
        for (int i = 0; i < skip; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.state_out !== 128'd0) begin bad++; $display("FAIL midrst_state got=%h want=0", bus.state_out); end
        rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_after_valid got=%b want=0", bus.out_valid); end
        exp_q.push_back({4{32'hDB135345}});
        send({4{32'h8E4DA1BC}});
        wait_out(n);
        e = exp_q.pop_front();
        total++; if (bus.state_out !== e) begin bad++; $display("FAIL midrst_fresh got=%h want=%h", bus.state_out, e); end
        take();
    endtask

    task automatic test_back_to_back();
        logic [127:0] stim [8];
        int got;
        for (int i = 0; i < 8; i++) stim[i] = {$urandom, $urandom, $urandom, $urandom};
        bus.out_ready = 1'b1;
        got = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    exp_q.push_back(mdl(stim[i], 1'b0));
                    send(stim[i]);
                end
            end
            begin
                logic [127:0] e;
                int cyc;
                cyc = 0;
                while (got < 8 && cyc < 400) begin
                    @(posedge clk); #1; cyc++;
                    if (bus.out_valid === 1'b1) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++; $display("FAIL b2b_extra got=%h want=none", bus.state_out);
                        end else begin
                            e = exp_q.pop_front();
                            if (bus.state_out !== e) begin bad++; $display("FAIL b2b_%0d got=%h want=%h", got, bus.state_out, e); end
                        end
                        got++;
                    end
                end
            end
        join
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        total++; if (got !== 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", got); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_left got=%0d want=0", exp_q.size()); end
    endtask

`ifdef INV_MIX_COLUMNS_FWD_EN
    task automatic test_fwd();
        int n;
        logic [127:0] e;
        fwd_sel = 1'b1;
        exp_q.push_back(V_IN);
        send(V_OUT);
        wait_out(n);
        total++; if (n !== LAT) begin bad++; $display("FAIL fwd_latency got=%0d want=%0d", n, LAT); end
        e = exp_q.pop_front();
        total++; if (bus.state_out !== e) begin bad++; $display("FAIL fwd_vector got=%h want=%h", bus.state_out, e); end
        take();
        fwd_sel = 1'b0;
        exp_q.push_back(V_OUT);
        send(V_IN);
        wait_out(n);
        e = exp_q.pop_front();
        total++; if (bus.state_out !== e) begin bad++; $display("FAIL fwd_roundtrip got=%h want=%h", bus.state_out, e); end
        take();
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.state_in  = 128'd0;
        bus.out_ready = 1'b0;
`ifdef INV_MIX_COLUMNS_FWD_EN
        bus.fwd = 1'b0;
`endif
        rst_n = 1'b0;
        test_reset();
        test_vector();
        test_columns();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
`ifdef INV_MIX_COLUMNS_FWD_EN
        test_fwd();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
